// File: rtl/ifmap_buffer_write_controller.sv
`default_nettype none
// ============================================================================
//  Module      : ifmap_buffer_write_controller
//  Description : Fetches one job of NUM_ROWS x ROW_LEN IFMap words from a
//                synchronous-read memory and pushes them into the IFMap
//                circular buffer as {start_row, end_row, data}. A one-entry
//                skid register behind the memory output keeps the stream
//                lossless under buf_ready backpressure at 1 word/cycle.
//                Optional build macro IFMAP_ZERO_PAD_EN frames every row with
//                a leading and a trailing zero word (no memory read for pads).
//  Revision    : 1.0 - initial release
// ============================================================================
module ifmap_buffer_write_controller #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int ROW_LEN    = 4,
    parameter int NUM_ROWS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    output logic                    mem_ren,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_dout,
    input  logic                    buf_ready,
    output logic                    wen_buf,
    output logic [DATA_WIDTH+1:0]   buf_din,
    output logic                    busy,
    output logic                    done
);

    // Output slots per row: data words, plus two pad words when padding.
`ifdef IFMAP_ZERO_PAD_EN
    localparam int c_slots = ROW_LEN + 2;
`else
    localparam int c_slots = ROW_LEN;
`endif
    localparam int c_col_w = (c_slots > 1) ? $clog2(c_slots) : 1;
    localparam int c_row_w = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(c_slots - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [c_col_w-1:0]      r_col;
    logic [c_row_w-1:0]      r_row;

    // Stage holding the tags of the slot issued last cycle (data is mem_dout).
    logic                    r_stg_vld;
    logic                    r_stg_pad;
    logic                    r_stg_start;
    logic                    r_stg_end;

    logic                    r_skid_vld;
    logic [DATA_WIDTH+1:0]   r_skid_word;

    logic [DATA_WIDTH+1:0]   w_stg_word;
    logic                    w_out_vld;
    logic [DATA_WIDTH+1:0]   w_out_word;
    logic                    w_slot_free;
    logic                    w_issue;
    logic                    w_slot_pad;
    logic                    w_slot_start;
    logic                    w_slot_end;
    logic                    w_last_slot;

    // Slot classification: which tags this slot carries and whether it is a pad.
`ifdef IFMAP_ZERO_PAD_EN
    assign w_slot_pad   = (r_col == '0) || (r_col == c_col_last);
`else
    assign w_slot_pad   = 1'b0;
`endif
    assign w_slot_start = (r_col == '0);
    assign w_slot_end   = (r_col == c_col_last);
    assign w_last_slot  = (r_row == c_row_last) && (r_col == c_col_last);

    // Output slot is the skid register if occupied, otherwise the returning word.
    // At most one of the two is ever valid because a slot is only issued when
    // the output slot is guaranteed to be empty by the time it returns.
    assign w_stg_word  = {r_stg_start, r_stg_end, r_stg_pad ? {DATA_WIDTH{1'b0}} : mem_dout};
    assign w_out_vld   = r_skid_vld | r_stg_vld;
    assign w_out_word  = r_skid_vld ? r_skid_word : w_stg_word;
    assign w_slot_free = ~w_out_vld | buf_ready;
    assign w_issue     = (r_state == ST_FETCH) && w_slot_free;

    assign wen_buf  = w_out_vld & buf_ready;
    assign buf_din  = w_out_vld ? w_out_word : '0;
    assign mem_ren  = w_issue & ~w_slot_pad;
    assign mem_addr = r_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status decode.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (init) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy = 1'b1;
                if (w_issue && w_last_slot) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Output slot empties this cycle and nothing else is pending.
                if (w_slot_free) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address, column and row counters; advance once per issued slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if ((r_state == ST_IDLE) && init) begin
            r_addr <= base_addr;
            r_col  <= '0;
            r_row  <= '0;
        end else if (w_issue) begin
            if (mem_ren) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            if (r_col == c_col_last) begin
                r_col <= '0;
                r_row <= r_row + c_row_w'(1);
            end else begin
                r_col <= r_col + c_col_w'(1);
            end
        end
    end

    // Tags travel alongside the read so they line up with mem_dout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stg_vld   <= 1'b0;
            r_stg_pad   <= 1'b0;
            r_stg_start <= 1'b0;
            r_stg_end   <= 1'b0;
        end else begin
            r_stg_vld   <= w_issue;
            r_stg_pad   <= w_slot_pad;
            r_stg_start <= w_slot_start;
            r_stg_end   <= w_slot_end;
        end
    end

    // Skid register: catches a returning word the buffer could not take.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_skid_vld  <= 1'b0;
            r_skid_word <= '0;
        end else if (r_skid_vld) begin
            if (buf_ready) begin
                r_skid_vld <= 1'b0;
            end
        end else if (r_stg_vld && !buf_ready) begin
            r_skid_vld  <= 1'b1;
            r_skid_word <= w_stg_word;
        end
    end

endmodule
`default_nettype wire
